// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide, one step per cycle, then a single sign-fix cycle.
module mul_div_unit #(
  parameter int unsigned ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  mdOP,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned CntW = $clog2(ITER);
  localparam logic [CntW-1:0] LastCnt = CntW'(ITER - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [63:0]     acc_q, acc_d;
  logic [31:0]     opnd_q, opnd_d;
  logic            neg_res_q, neg_res_d;
  logic            neg_rem_q, neg_rem_d;
  logic            is_div_q, is_div_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic        signed_op;
  logic [31:0] abs_a, abs_b, opa, opb;
  logic [32:0] mul_sum;
  logic [32:0] div_trial, div_diff;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign signed_op = ~mdOP[2] & ~mdOP[0];
  assign abs_a     = a[31] ? (~a + 32'd1) : a;
  assign abs_b     = b[31] ? (~b + 32'd1) : b;
  assign opa       = signed_op ? abs_a : a;
  assign opb       = signed_op ? abs_b : b;

  // Accumulator holds {partial product, remaining multiplier bits} during MUL.
  assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);

  // Accumulator holds {partial remainder, dividend/quotient bits} during DIV.
  assign div_trial = {acc_q[63:32], acc_q[31]};
  assign div_diff  = div_trial - {1'b0, opnd_q};

  assign prod_fix  = neg_res_q ? (~acc_q + 64'd1) : acc_q;
  assign quo_fix   = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
  assign rem_fix   = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    is_div_d  = is_div_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          unique case (mdOP)
            3'b000, 3'b001: begin
              state_d   = StMul;
              cnt_d     = '0;
              acc_d     = {32'd0, opb};
              opnd_d    = opa;
              neg_res_d = signed_op & (a[31] ^ b[31]);
              neg_rem_d = 1'b0;
              is_div_d  = 1'b0;
            end
            3'b010, 3'b011: begin
              state_d   = StDiv;
              cnt_d     = '0;
              acc_d     = {32'd0, opa};
              opnd_d    = opb;
              // Divide by zero keeps the all-ones quotient un-negated.
              neg_res_d = signed_op & (a[31] ^ b[31]) & (b != 32'd0);
              neg_rem_d = signed_op & a[31];
              is_div_d  = 1'b1;
            end
            3'b100:  hi_d = a;
            3'b101:  lo_d = a;
            default: ;
          endcase
        end
      end
      StMul: begin
        acc_d = {mul_sum, acc_q[31:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) state_d = StFix;
      end
      StDiv: begin
        if (div_trial >= {1'b0, opnd_q}) acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
        else                             acc_d = {div_trial[31:0], acc_q[30:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) state_d = StFix;
      end
      StFix: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      is_div_q  <= is_div_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: arithmetic reference model checked every cycle,
// plus directed literal checks for the corner cases.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [2:0]  mdOP = '0;
  logic        start = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  mul_div_unit #(.ITER(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .mdOP  (mdOP),
    .start (start),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: result computed with plain arithmetic at acceptance, released after
  // 33 further edges.
  int          m_cnt  = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  logic [31:0] p_hi, p_lo;

  task automatic compute(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] rh, output logic [31:0] rl);
    logic [63:0] prod;
    int sx, sy;
    sx = $signed(x);
    sy = $signed(y);
    rh = '0;
    rl = '0;
    case (op)
      3'd0: begin
        prod = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        rh = prod[63:32]; rl = prod[31:0];
      end
      3'd1: begin
        prod = {32'd0, x} * {32'd0, y};
        rh = prod[63:32]; rl = prod[31:0];
      end
      3'd2: begin
        if (y == 0) begin rh = x; rl = 32'hFFFF_FFFF; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin rh = 0; rl = 32'h8000_0000; end
        else begin rl = sx / sy; rh = sx % sy; end
      end
      3'd3: begin
        if (y == 0) begin rh = x; rl = 32'hFFFF_FFFF; end
        else begin rl = x / y; rh = x % y; end
      end
      default: ;
    endcase
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt = 0; m_done = 1'b0; m_hi = '0; m_lo = '0;
    end else begin
      m_done = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
        end
      end else if (start) begin
        if (mdOP <= 3'd3) begin
          compute(mdOP, a, b, p_hi, p_lo);
          m_cnt = 33;
        end else if (mdOP == 3'd4) m_hi = a;
        else if (mdOP == 3'd5) m_lo = a;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {63'd0, busy}, {63'd0, (m_cnt > 0)});
      chk("done", {63'd0, done}, {63'd0, m_done});
      chk("hi", {32'd0, hi}, {32'd0, m_hi});
      chk("lo", {32'd0, lo}, {32'd0, m_lo});
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                       input bit now);
    if (!now) @(negedge clk);
    start = 1'b1; mdOP = op; a = x; b = y;
    @(negedge clk);
    start = 1'b0; mdOP = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(input string name, input int exp_lat);
    int lat = 0;
    while (!done && lat < 45) begin
      @(negedge clk);
      lat++;
    end
    chk(name, 64'(lat), 64'(exp_lat));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      4:       return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit saw_done;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_hi", {32'd0, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);

    // Start on the very first edge after release.
    @(posedge clk); #2 rst = 1'b1;
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done("multu_latency", 33);
    chk("multu_hi", {32'd0, hi}, 64'hFFFF_FFFE);
    chk("multu_lo", {32'd0, lo}, 64'h0000_0001);

    issue(3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
    wait_done("mult_latency", 33);
    chk("mult_hi", {32'd0, hi}, 64'hFFFF_FFFF);
    chk("mult_lo", {32'd0, lo}, 64'hFFFF_FFEB);
    issue(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    wait_done("div_latency", 33);
    chk("div_lo", {32'd0, lo}, 64'hFFFF_FFFD);
    chk("div_hi", {32'd0, hi}, 64'hFFFF_FFFF);

    issue(3'd3, 32'h0000_0064, 32'h0, 1'b0);
    wait_done("divu0_latency", 33);
    chk("divu0_hi", {32'd0, hi}, 64'h0000_0064);
    chk("divu0_lo", {32'd0, lo}, 64'hFFFF_FFFF);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_done("divovf_latency", 33);
    chk("divovf_lo", {32'd0, lo}, 64'h8000_0000);
    chk("divovf_hi", {32'd0, hi}, 64'h0);

    // Start during busy is ignored; start in the done cycle is accepted.
    issue(3'd0, 32'd5, 32'hFFFF_FFF7, 1'b0);
    repeat (4) @(negedge clk);
    issue(3'd3, 32'd1000, 32'd7, 1'b0);
    wait_done("ignored_latency", 27);
    chk("ignored_hi", {32'd0, hi}, 64'hFFFF_FFFF);
    chk("ignored_lo", {32'd0, lo}, 64'hFFFF_FFD3);
    issue(3'd1, 32'd2, 32'd3, 1'b1);
    chk("b2b_busy", {63'd0, busy}, 64'd1);
    wait_done("b2b_latency", 33);
    chk("b2b_lo", {32'd0, lo}, 64'd6);

    issue(3'd4, 32'h1234_5678, 32'h0, 1'b0);
    chk("mthi_hi", {32'd0, hi}, 64'h1234_5678);
    chk("mthi_busy", {63'd0, busy}, 64'd0);
    issue(3'd5, 32'h9ABC_DEF0, 32'h0, 1'b0);
    chk("mtlo_lo", {32'd0, lo}, 64'h9ABC_DEF0);
    chk("mtlo_hi", {32'd0, hi}, 64'h1234_5678);
    chk("mtlo_done", {63'd0, done}, 64'd0);

    // Reset mid-divide aborts with no later done.
    issue(3'd3, $urandom, $urandom_range(1, 1000), 1'b0);
    repeat (9) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #2 rst = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("no_done_after_rst", {63'd0, saw_done}, 64'd0);
    issue(3'd1, 32'd2, 32'd3, 1'b0);
    wait_done("post_rst_latency", 33);
    chk("post_rst_lo", {32'd0, lo}, 64'd6);
    chk("post_rst_hi", {32'd0, hi}, 64'd0);

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      mdOP  = 3'($urandom_range(0, 7));
      a     = pick();
      b     = pick();
    end
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter: ITER, 32, number of iteration cycles per multiply/divide (fixed at 32; other values unsupported).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 a  input  32  operand A (multiplicand / dividend / MTHI-MTLO source).
REQ-005 b  input  32  operand B (multiplier / divisor).
REQ-006 mdOP  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op.
REQ-007 start  input  1  request strobe; sampled with a, b and mdOP on the rising clk edge.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse marking HI/LO update by MULT/MULTU/DIV/DIVU.
REQ-010 hi  output  32  HI register (product[63:32] / remainder).
REQ-011 lo  output  32  LO register (product[31:0] / quotient).

Function
REQ-012 States: IDLE, MUL, DIV, FIX; busy SHALL be 1 exactly in MUL, DIV and FIX.
REQ-013 IDLE with start=1: op 000/001 -> MUL; op 010/011 -> DIV; op 100/101 -> stay IDLE; other ops -> no-op.
REQ-014 start while busy=1 SHALL be ignored; no queuing; hi/lo and the in-flight operation unchanged.
REQ-015 MTHI/MTLO accepted in IDLE SHALL write a into hi/lo at that edge, leave the other register unchanged, assert neither busy nor done.
REQ-016 Signed ops (000, 010) SHALL latch |a|, |b| and the result signs at acceptance; unsigned ops latch a, b unchanged.
REQ-017 MUL: 32 shift-add iterations, one per cycle, on a 64-bit accumulator; DIV: 32 restoring shift-subtract iterations, one per cycle, on 32-bit partial remainder and quotient.
REQ-018 After iteration 32 the FSM SHALL enter FIX for one cycle, apply two's-complement sign correction, write hi/lo, return to IDLE.
REQ-019 Latency: start accepted at edge E0 -> busy=1 after E0 through E33; hi/lo updated and done=1 after E33 for exactly one cycle; busy=0 in that same cycle.
REQ-020 A new start SHALL be accepted in the cycle done=1 (back-to-back, zero idle cycles).
REQ-021 Signed multiply: 64-bit product negated iff a[31]^b[31]; MULTU product unsigned; no overflow flag.
REQ-022 Signed divide: quotient negated iff a[31]^b[31]; remainder takes the sign of a; |remainder| < |b|.
REQ-023 Divide by zero (DIV or DIVU, b=0): full 32-cycle latency; hi=a, lo=32'hFFFFFFFF; done pulses normally.
REQ-024 DIV 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0 (wrap, no trap).
REQ-025 Operands a, b, mdOP MAY change after the acceptance edge without affecting the in-flight result.
REQ-026 hi and lo SHALL remain stable between updates; outputs driven only from registers.

Reset
REQ-027 rst=0 SHALL asynchronously force state=IDLE, busy=0, done=0, hi=0, lo=0 and clear all internal accumulators/counters.
REQ-028 Reset asserted mid-operation SHALL abort it; no done pulse after release; first start after release behaves as from power-up.
REQ-029 start during the first rising edge after rst deassertion SHALL be accepted normally.

Verification
REQ-030 MULTU a=FFFFFFFF, b=FFFFFFFF -> done after 34th edge, hi=FFFFFFFE, lo=00000001.
REQ-031 MULT a=FFFFFFFD(-3), b=00000007 -> hi=FFFFFFFF, lo=FFFFFFEB (-21); then DIV a=FFFFFFF9(-7), b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF.
REQ-032 DIVU a=00000064, b=0 -> hi=00000064, lo=FFFFFFFF; DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
REQ-033 start pulsed at cycle 5 of a MULT with different op -> ignored, original result correct; new start in done cycle -> accepted, busy stays 1.
REQ-034 MTHI a=12345678 then MTLO a=9ABCDEF0 -> hi=12345678, lo=9ABCDEF0, busy and done never 1.
REQ-035 rst=0 at cycle 10 of a DIVU -> hi=lo=0, busy=0 immediately; no done after release; next MULTU 2x3 -> lo=6, hi=0.
